// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the paged 7-segment display scanner.
package seg7_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned PAGES  = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; A-E render as a dash, F as blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hF:    seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Nearest valid page above cur (wrapping); cur itself when no other page is valid.
  function automatic logic [1:0] next_valid_page(input logic [3:0] valid,
                                                 input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (valid[idx]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = seg7_decode(i_bcd);

endmodule

// File: rtl/seg7_page_scan.sv
// Rotates four status pages on synchronized clk7seg ticks and time-multiplexes
// the four digits with a blanking window at the start of each slot.
module seg7_page_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 12500,
  parameter int unsigned BLANK_CYC  = 2,
  parameter int unsigned PAGE_TICKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7seg,
  input  logic [63:0] page_bcd,
  input  logic [3:0]  page_valid,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic [1:0]  page_idx
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned TICK_W = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic [1:0]        r_fill;
  logic              r_armed;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [1:0]        r_page_idx;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_dig_idx;
  logic [6:0]        r_seg;
  logic [3:0]        r_dig_en;

  logic              w_tick;
  logic              w_none_valid;
  logic [1:0]        w_next_page;
  logic [5:0]        w_nib_lsb;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg_dec;
  logic              w_blank;

  // A tick needs a low level seen after the pipeline filled, so a level
  // already high when reset releases never produces a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= clk7seg;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_sync2);
    end
  end

  assign w_tick       = r_armed & r_sync2 & ~r_prev;
  assign w_none_valid = (page_valid == 4'b0000);
  assign w_next_page  = next_valid_page(page_valid, r_page_idx);

  // Invalid-page jump takes priority over ticks and ignores hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_page_idx <= 2'd0;
    end else if (!w_none_valid) begin
      if (!page_valid[r_page_idx]) begin
        r_page_idx <= w_next_page;
        r_tick_cnt <= '0;
      end else if (w_tick && !hold) begin
        if (r_tick_cnt == TICK_W'(PAGE_TICKS - 1)) begin
          r_tick_cnt <= '0;
          r_page_idx <= w_next_page;
        end else begin
          r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= 2'd0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= r_dig_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign w_nib_lsb = {r_page_idx, r_dig_idx, 2'b00};
  assign w_nibble  = page_bcd[w_nib_lsb +: 4];
  assign w_blank   = (r_scan_cnt < SCAN_W'(BLANK_CYC)) || w_none_valid;

  bcd_to_seg7 u_dec (
    .i_bcd   (w_nibble),
    .o_seg_c (w_seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg    <= SEG_BLANK;
      r_dig_en <= 4'b1111;
    end else if (w_blank) begin
      r_seg    <= SEG_BLANK;
      r_dig_en <= 4'b1111;
    end else begin
      r_seg    <= w_seg_dec;
      r_dig_en <= ~(4'b0001 << r_dig_idx);
    end
  end

  assign seg      = r_seg;
  assign dig_en   = r_dig_en;
  assign page_idx = r_page_idx;

endmodule

// File: tb/tb_seg7_page_scan.sv
// Directed and randomized bench for seg7_page_scan against a behavioural display model.
module tb_seg7_page_scan;

  localparam int SD = 4;
  localparam int BL = 1;
  localparam int PT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7seg;
  logic [63:0] page_bcd;
  logic [3:0]  page_valid;
  logic        hold;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [1:0]  page_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};

  // Model state: absolute scan position, page, ticks counted, recent clk7seg samples.
  int         m_t;
  int         m_page;
  int         m_cnt;
  logic       m_hist [$];
  logic [6:0] m_seg;
  logic [3:0] m_dig;
  int         saved_page;

  always #5 clk = ~clk;

  seg7_page_scan #(.SCAN_DIV(SD), .BLANK_CYC(BL), .PAGE_TICKS(PT)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk7seg    (clk7seg),
    .page_bcd   (page_bcd),
    .page_valid (page_valid),
    .hold       (hold),
    .seg        (seg),
    .dig_en     (dig_en),
    .page_idx   (page_idx)
  );

  function automatic int next_page(input logic [3:0] v, input int p);
    for (int k = 1; k <= 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_page = 0; m_cnt = 0;
    m_hist.delete();
    m_seg = 7'h7F; m_dig = 4'hF;
  endtask

  // One clock edge of the reference display, using inputs as seen at that edge.
  task automatic model_edge();
    int   off, slot;
    logic tick;
    if (reset) begin
      model_reset();
      return;
    end
    tick = (m_hist.size() == 3) && m_hist[1] && !m_hist[0];
    off  = m_t % SD;
    slot = m_t / SD;
    if (off < BL || page_valid == 4'b0000) begin
      m_seg = 7'h7F;
      m_dig = 4'hF;
    end else begin
      m_seg = dec_tab[page_bcd[16*m_page + 4*slot +: 4]];
      m_dig = ~(4'(1) << slot);
    end
    if (page_valid != 4'b0000) begin
      if (!page_valid[m_page]) begin
        m_page = next_page(page_valid, m_page);
        m_cnt  = 0;
      end else if (tick && !hold) begin
        if (m_cnt == PT - 1) begin
          m_cnt  = 0;
          m_page = next_page(page_valid, m_page);
        end else begin
          m_cnt++;
        end
      end
    end
    m_t = (m_t + 1) % (4 * SD);
    m_hist.push_back(clk7seg);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("seg", 32'(seg), 32'(m_seg));
    chk("dig_en", 32'(dig_en), 32'(m_dig));
    chk("page_idx", 32'(page_idx), 32'(m_page));
  endtask

  task automatic pulse();
    clk7seg = 1'b1;
    repeat (3) step();
    clk7seg = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b1; clk7seg = 1'b0; hold = 1'b0;
    page_bcd = 64'h0000_0000_0000_1234; page_valid = 4'b0001;
    model_reset();
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dig_en", 32'(dig_en), 32'hF);
    chk("rst_page", 32'(page_idx), 32'h0);
    repeat (3) step();

    // First slots show 4,3,2,1.
    reset = 1'b0;
    repeat (20) step();

    // Rotation through all pages.
    page_valid = 4'b1111;
    page_bcd   = {$urandom, $urandom};
    repeat (4) pulse();
    repeat (4) step();

    // Skip and wrap with pages 0 and 3, then invalidate page 0.
    page_valid = 4'b1001;
    repeat (4) pulse();
    for (int k = 0; k < 6 && m_page != 0; k++) pulse();
    page_valid = 4'b1000;
    step();
    chk("invalid_jump", 32'(page_idx), 32'd3);
    repeat (3) step();

    // Hold freezes rotation across five edges.
    page_valid = 4'b1111;
    repeat (3) step();
    saved_page = m_page;
    hold = 1'b1;
    repeat (5) pulse();
    chk("hold_page", 32'(page_idx), 32'(saved_page));
    hold = 1'b0;
    repeat (2) pulse();

    // All invalid, then dash and blank nibbles.
    page_valid = 4'b0000;
    repeat (12) step();
    page_bcd   = 64'h0000_0000_0000_F0FA;
    page_valid = 4'b0001;
    repeat (20) step();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) clk7seg = ~clk7seg;
      if ($urandom_range(0, 39) == 0) page_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      if ($urandom_range(0, 9) == 0) page_bcd = {$urandom, $urandom};
      step();
    end

    // Reset mid-slot, with clk7seg held high across release.
    hold = 1'b0; clk7seg = 1'b0; page_valid = 4'b1111;
    for (int k = 0; k < 2 * SD && (m_t % SD) != 2; k++) step();
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dig_en", 32'(dig_en), 32'hF);
    chk("midrst_page", 32'(page_idx), 32'h0);
    clk7seg = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    clk7seg = 1'b0;
    repeat (3) step();
    pulse();
    chk("no_tick_at_release", 32'(page_idx), 32'h0);
    pulse();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_page_scan.md
# seg7_page_scan

Consumer of the divided 7-segment clock (`clk7seg`) in the irrigation controller. It synchronizes the slow clock into the system clock domain and uses each rising edge as a tick. Ticks rotate the 4-digit display through up to four status pages (moisture, tank level, valve timer, mode). Independently, it time-multiplexes the four digits at a fast scan rate, with BCD-to-segment decoding and anti-ghosting blanking.

## Interface
- `SCAN_DIV`, 12500: system-clock cycles per digit slot (≥4)
- `BLANK_CYC`, 2: cycles at the start of each slot with all digits disabled (< `SCAN_DIV`)
- `PAGE_TICKS`, 3: `clk7seg` rising edges per page (≥1)
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `clk7seg` in 1: slow divided clock, treated as asynchronous data
- `page_bcd` in 64: page p occupies bits [16p+15:16p]; digit d is nibble [4d+3:4d], and digit 0 is rightmost
- `page_valid` in 4: page enable mask
- `hold` in 1: freeze page rotation
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low
- `dig_en` out 4: digit enables, active-low, bit d = digit d
- `page_idx` out 2: page currently displayed

## Operation
- **Tick generation.** `clk7seg` passes through a 2-FF synchronizer, then a third register. `tick` = sync & ~prev, one cycle wide.
- **Tick counter.**
  - Range 0..`PAGE_TICKS`-1. Increments on `tick` when `hold`=0.
  - At `PAGE_TICKS`-1 plus a tick, it wraps to 0 and the page advances.
  - `hold`=1 freezes both the counter and the page; ticks arriving during hold are discarded.
- **Page advance.** `page_idx` moves to the next index with `page_valid`=1, searching upward with wrap from 3 to 0. If the only valid page is the current one, `page_idx` is unchanged.
- **Invalid current page.**
  - If `page_valid[page_idx]`=0 while other pages are valid, `page_idx` jumps to the next valid page on the next clk, without waiting for a tick, and the tick counter clears to 0. `hold` does not block this.
  - If `page_valid`=0000, `page_idx` is held, the display is blank (`dig_en`=1111, `seg`=7F), and the scan counters keep running.
- **Scan.**
  - `scan_cnt` runs 0..`SCAN_DIV`-1. On wrap, `dig_idx` increments 0→1→2→3→0.
  - Scanning never stops, including during `hold`.
- **Output register**, updated every clk:
  - while `scan_cnt` < `BLANK_CYC`: `dig_en`=1111, `seg`=7F.
  - else: `dig_en` = ~(1<<`dig_idx`), `seg` = decode(nibble `dig_idx` of page `page_idx`).
- **Decode (active-low):**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A–E = 3F (dash).
  - F = 7F (blank).
- `page_bcd` is sampled live; a change appears at the next non-blank output cycle for the addressed digit.

## Timing
- **Reset values:** `seg`=7F, `dig_en`=1111, `page_idx`=0. `scan_cnt`, `dig_idx`, tick counter and synchronizer regs are all 0.
- **Tick latency:** `clk7seg` rising edge → `tick` asserted 2–3 clk later.
- **Page latency:** the tick that completes the count → `page_idx` updates on the following clk edge. `seg`/`dig_en` reflect the new page one clk after that, unless in a blank window.
- **Digit slot:**
  - Slot d begins on the cycle `scan_cnt`=0 with `dig_idx`=d.
  - Because outputs are registered, `dig_en` stays 1111 for `BLANK_CYC` clk after the slot starts (observed one clk later).
  - The digit is then active for `SCAN_DIV`-`BLANK_CYC` cycles.
- **Simultaneous events:**
  - tick together with a `page_valid` change that invalidates the current page: the invalid-jump wins and the tick counter clears.
  - tick together with `hold` rising: the tick is ignored.
- **Reset mid-operation:** every register returns to its reset value immediately (asynchronous). The first tick after release requires a fresh rising edge of `clk7seg`; a level already high at release does not tick.

## Structure
- Package `seg7_pkg`:
  - constants `SEG_BLANK`=7'h7F and `SEG_DASH`=7'h3F
  - the 16-entry digit decode function
  - `DIGITS`=4 and `PAGES`=4
- Sub-module `bcd_to_seg7` is the combinational decoder, used once for the selected nibble.
- Synchronizer and edge detect stay inline. Next-valid-page search is a small priority function in the package.

## Test plan
- **Reset and first tick.** `SCAN_DIV`=4, `BLANK_CYC`=1, `PAGE_TICKS`=2. Hold `reset`, then release with `page_bcd`=64'h0000_0000_0000_1234 and `page_valid`=0001.
  - During reset: `seg`=7F, `dig_en`=F, `page_idx`=0.
  - Digit slots then show 4,3,2,1 (`seg` 19,30,24,79) with `dig_en` E,D,B,7, each preceded by one all-off cycle.
- **Page rotation.** `page_valid`=1111, `PAGE_TICKS`=2, four `clk7seg` rising edges → `page_idx` goes 0→1→2, changing 2–4 clk after the 2nd and 4th edges.
- **Skip and wrap.** `page_valid`=1001, `page_idx`=3, then a completing tick → `page_idx`=0. Clear bit 0 while on page 0 → `page_idx`=3 next clk with no tick.
- **Hold.** Assert `hold`, apply 5 edges → `page_idx` unchanged and scanning continues. Release `hold` → two further edges are needed to advance.
- **All invalid and codes.** `page_valid`=0000 → `dig_en`=F continuously. Restore it with nibbles A and F → `seg`=3F and 7F respectively, and `dig_en` still asserts for the F slot.
- **Reset mid-slot.** Assert `reset` with `scan_cnt`=2 → outputs are at reset values that same cycle. A `clk7seg` held high across release produces no tick.
